mnist_frame_driver: RTL and testbench
=====================================

Name: mnist_frame_driver

Overview:
- Host-side initiator for the digit-classifier core: accepts an 8-bit grayscale pixel stream and binarizes each pixel against a threshold.
- Packs pixels into one 784-bit frame and drives the core's valid/ready image interface.
- Captures the core's 4-bit label pulse and returns it to the host on a held valid/ready result port, with timeout protection.
- Sits between the host pixel source (UART/DMA adapter) and the classifier core.

Parameters:
- PIXELS, 784, pixels per frame (28x28).
- THRESH, 128, binarization threshold; pixel >= THRESH -> 1.
- LABEL_W, 4, label width.
- TIMEOUT, 1024, max cycles in S_WAIT before timeout; must be >= 2.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- pix_valid_i  in  1  host pixel valid
- pix_data_i  in  8  grayscale pixel, raster order
- pix_ready_o  out  1  driver accepts pixel
- model_valid_o  out  1  frame valid to core
- model_data_o  out  PIXELS  packed binary frame; bit i = pixel i
- model_ready_i  in  1  core ready
- model_valid_i  in  1  core label valid (single-cycle pulse)
- model_data_i  in  LABEL_W  core label
- model_ready_o  out  1  driver accepting label
- label_valid_o  out  1  result valid to host
- label_data_o  out  LABEL_W  result label
- label_err_o  out  1  result is an error (timeout or range)
- label_ready_i  in  1  host accepts result
- busy_o  out  1  state != S_LOAD or pixel count != 0

Behaviour:
- Reset (async assert, sync release):
  - state=S_LOAD, pixel count=0, frame=0, timer=0.
  - All outputs 0 except pix_ready_o=1.
  - Reset mid-frame discards partial data; no handshake is completed.
- S_LOAD:
  - pix_ready_o=1. On pix_valid_i, frame[count] <= (pix_data_i >= THRESH); count++.
  - Accepting pixel PIXELS-1 -> count=0, next state S_SEND. pix_ready_o drops the following cycle.
- S_SEND:
  - model_valid_o=1; model_data_o stays stable until model_valid_o&&model_ready_i.
  - On handshake -> S_WAIT, timer=0. model_valid_o deasserts the next cycle.
  - model_ready_o=0 here; any model_valid_i in S_SEND is ignored.
- S_WAIT:
  - model_ready_o=1, timer increments each cycle.
  - On model_valid_i: label <= model_data_i, err<=0 -> S_OUT.
  - If timer reaches TIMEOUT-1 without model_valid_i: label <= all-ones (4'hF), err<=1 -> S_OUT.
  - model_valid_i on the timeout cycle wins over timeout.
  - A core responding one cycle after acceptance is captured with zero loss.
- S_OUT:
  - label_valid_o=1; label_data_o/label_err_o held stable until label_ready_i. Then -> S_LOAD.
  - label_valid_o is registered, so there is no combinational path from label_ready_i.
- No pixel acceptance outside S_LOAD. Pixel-to-frame latency = PIXELS accepted beats + 1 cycle to model_valid_o.
- Frame register is retained after send (not cleared) until overwritten by the next frame's pixels.
- model_data_o/label_data_o are registered outputs.

Optional Feature:
- LABEL_CHECK_EN defined: a captured label > 9 is replaced by 4'hE with label_err_o=1.
- LABEL_CHECK_EN undefined: the label passes through raw; label_err_o is set only on timeout.

Test Plan:
- Basic frame:
  - Stimulus: 784 pixels, pixel i = (i%2)?200:50; model_ready_i=1; core returns label 8 one cycle after accept; label_ready_i=1.
  - Required: model_data_o = 784'hAAAA...A (odd bits set); label_valid_o=1 with label_data_o=8, label_err_o=0; back to S_LOAD.
- Threshold edge:
  - Stimulus: pixels 127, 128, 255, 0, rest 0.
  - Required: model_data_o[3:0]=4'b0110.
- Backpressure:
  - Stimulus: model_ready_i=0 for 20 cycles after the frame completes; label_ready_i=0 for 10 cycles.
  - Required: model_valid_o and label_valid_o held high with stable data; pix_ready_o=0 throughout; exactly one handshake each.
- Timeout:
  - Stimulus: TIMEOUT=16; core never responds.
  - Required: 16 cycles after the send handshake, label_valid_o=1, label_data_o=4'hF, label_err_o=1.
- Reset mid-frame:
  - Stimulus: reset_ni=0 after 300 pixels, release, then stream a full frame.
  - Required: outputs return to reset values immediately; the new frame bit 0 equals the first post-reset pixel; exactly 784 beats are accepted before model_valid_o.
- Range check (LABEL_CHECK_EN defined):
  - Stimulus: core returns 4'd12.
  - Required: label_data_o=4'hE, label_err_o=1.
  - Undefined: label_data_o=4'hC, label_err_o=0.

Source files
------------

// File: rtl/mnist_frame_driver_if.sv
// mnist_frame_driver_if
//   Bundles every handshake/data signal of the MNIST frame driver: the host
//   pixel stream, the image port and label port of the classifier core, the
//   result port back to the host and the busy flag.  Signal names keep the
//   driver's point of view (_i = into the driver, _o = out of the driver).
//
//   Modports:
//     master : the frame driver itself
//     slave  : the environment (host pixel source, classifier core, result sink)
//
//   Parameters: PIXELS (frame width in bits), LABEL_W (label width).
`timescale 1ns/1ps
interface mnist_frame_driver_if #(
   parameter int PIXELS  = 784,
   parameter int LABEL_W = 4
);
   // host pixel stream
   logic               pix_valid_i;
   logic [7:0]         pix_data_i;
   logic               pix_ready_o;
   // image port to the classifier core
   logic               model_valid_o;
   logic [PIXELS-1:0]  model_data_o;
   logic               model_ready_i;
   // label pulse from the classifier core
   logic               model_valid_i;
   logic [LABEL_W-1:0] model_data_i;
   logic               model_ready_o;
   // result port to the host
   logic               label_valid_o;
   logic [LABEL_W-1:0] label_data_o;
   logic               label_err_o;
   logic               label_ready_i;
   // status
   logic               busy_o;

   modport master (
      input  pix_valid_i, pix_data_i, model_ready_i, model_valid_i,
             model_data_i, label_ready_i,
      output pix_ready_o, model_valid_o, model_data_o, model_ready_o,
             label_valid_o, label_data_o, label_err_o, busy_o
   );

   modport slave (
      output pix_valid_i, pix_data_i, model_ready_i, model_valid_i,
             model_data_i, label_ready_i,
      input  pix_ready_o, model_valid_o, model_data_o, model_ready_o,
             label_valid_o, label_data_o, label_err_o, busy_o
   );
endinterface

// File: rtl/mnist_frame_driver.sv
// mnist_frame_driver
//   Host-side initiator for the digit-classifier core.  Binarizes an 8-bit
//   grayscale pixel stream against THRESH, packs PIXELS pixels into one frame,
//   offers the frame to the core, waits (with timeout) for the core's label
//   pulse and hands the label back to the host on a held valid/ready port.
//
//   Ports:
//     clk_i     : clock
//     reset_ni  : asynchronous active-low reset, synchronous release
//     bus       : mnist_frame_driver_if.master (pixel, image, label, result
//                 handshakes and busy_o)
//
//   Parameters: PIXELS, THRESH, LABEL_W, TIMEOUT (>= 2).
//
//   Build option: define LABEL_CHECK_EN to replace any captured label > 9 by
//   4'hE flagged as an error.  Without it the label passes through raw and
//   label_err_o flags timeouts only.
`timescale 1ns/1ps
module mnist_frame_driver #(
   parameter int PIXELS  = 784,
   parameter int THRESH  = 128,
   parameter int LABEL_W = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   mnist_frame_driver_if.master  bus
);

   localparam int CW = (PIXELS  > 1) ? $clog2(PIXELS)  : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t             state_reg,  state_next;
   logic [CW-1:0]      count_reg,  count_next;
   logic [PIXELS-1:0]  frame_reg,  frame_next;
   logic [TW-1:0]      timer_reg,  timer_next;
   logic [LABEL_W-1:0] label_reg,  label_next;
   logic               err_reg,    err_next;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg <= S_LOAD;
         count_reg <= '0;
         frame_reg <= '0;
         timer_reg <= '0;
         label_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         frame_reg <= frame_next;
         timer_reg <= timer_next;
         label_reg <= label_next;
         err_reg   <= err_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      frame_next = frame_reg;
      timer_next = timer_reg;
      label_next = label_reg;
      err_next   = err_reg;

      case (state_reg)
         S_LOAD: begin
            if (bus.pix_valid_i) begin
               frame_next[count_reg] = (int'(bus.pix_data_i) >= THRESH);
               if (count_reg == CW'(PIXELS - 1)) begin
                  count_next = '0;
                  state_next = S_SEND;
               end else begin
                  count_next = count_reg + CW'(1);
               end
            end
         end

         S_SEND: begin
            // Label pulses arriving here are dropped: model_ready_o is low.
            if (bus.model_ready_i) begin
               state_next = S_WAIT;
               timer_next = '0;
            end
         end

         S_WAIT: begin
            // A real label on the last timer cycle takes priority over timeout.
            if (bus.model_valid_i) begin
               state_next = S_OUT;
`ifdef LABEL_CHECK_EN
               if (bus.model_data_i > LABEL_W'(9)) begin
                  label_next = LABEL_W'(14);
                  err_next   = 1'b1;
               end else begin
                  label_next = bus.model_data_i;
                  err_next   = 1'b0;
               end
`else
               label_next = bus.model_data_i;
               err_next   = 1'b0;
`endif
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               state_next = S_OUT;
               label_next = '1;
               err_next   = 1'b1;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end

         S_OUT: begin
            if (bus.label_ready_i) begin
               state_next = S_LOAD;
            end
         end

         default: begin
            state_next = S_LOAD;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from registered state only, so no input-to-output
   // combinational paths exist (in particular none from label_ready_i).
   // ------------------------------------------------------------------
   assign bus.pix_ready_o   = (state_reg == S_LOAD);
   assign bus.model_valid_o = (state_reg == S_SEND);
   assign bus.model_data_o  = frame_reg;
   assign bus.model_ready_o = (state_reg == S_WAIT);
   assign bus.label_valid_o = (state_reg == S_OUT);
   assign bus.label_data_o  = label_reg;
   assign bus.label_err_o   = err_reg;
   assign bus.busy_o        = (state_reg != S_LOAD) || (count_reg != '0);

endmodule

// File: tb/tb_mnist_frame_driver.sv
// tb_mnist_frame_driver
//   Directed bench for mnist_frame_driver (TIMEOUT reduced to 16).  The
//   stimulus process pushes hand-computed expected frames and labels into
//   queues; a monitor on the falling clock edge pops and compares them at
//   every image and result handshake, and counts accepted pixel beats.
`timescale 1ns/1ps
module tb_mnist_frame_driver;
   localparam int PIXELS  = 784;
   localparam int LABEL_W = 4;
   localparam int TIMEOUT = 16;

   logic clk_i    = 1'b0;
   logic reset_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   mnist_frame_driver_if #(.PIXELS(PIXELS), .LABEL_W(LABEL_W)) bus ();

   mnist_frame_driver #(
      .PIXELS  (PIXELS),
      .THRESH  (128),
      .LABEL_W (LABEL_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int beats    = 0;
   int model_hs = 0;
   int label_hs = 0;

   logic [PIXELS-1:0]  frame_q[$];
   logic [LABEL_W:0]   label_q[$];   // {err, label}

   localparam logic [PIXELS-1:0] FRAME_ALT   = {392{2'b10}};
   localparam logic [PIXELS-1:0] FRAME_EDGE  = 784'h6;
   localparam logic [PIXELS-1:0] FRAME_ONES  = {PIXELS{1'b1}};
   localparam logic [PIXELS-1:0] FRAME_ZERO  = '0;
   localparam logic [PIXELS-1:0] FRAME_ENDS  = {1'b1, 782'b0, 1'b1};

   task automatic chk(input string name, input logic [PIXELS-1:0] act,
                      input logic [PIXELS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------
   always @(negedge clk_i) begin
      logic [PIXELS-1:0] ef;
      logic [LABEL_W:0]  el;
      if (!reset_ni) begin
         beats = 0;
      end else begin
         if (bus.pix_valid_i && bus.pix_ready_o) beats++;
         if (bus.model_valid_o && bus.model_ready_i) begin
            model_hs++;
            if (frame_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL frame_unexpected: got handshake #%0d, required none", model_hs);
            end else begin
               ef = frame_q.pop_front();
               chk("frame_data", bus.model_data_o, ef);
            end
            chk("beats_before_frame", beats, PIXELS);
            $display("frame handshake #%0d after %0d beats", model_hs, beats);
            beats = 0;
         end
         if (bus.label_valid_o && bus.label_ready_i) begin
            label_hs++;
            if (label_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL label_unexpected: got handshake #%0d, required none", label_hs);
            end else begin
               el = label_q.pop_front();
               chk("label_result", {bus.label_err_o, bus.label_data_o}, el);
            end
            $display("label handshake #%0d: label=%0h err=%0b", label_hs,
                     bus.label_data_o, bus.label_err_o);
         end
      end
   end

   // ---------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [7:0] pix_val(input int pat, input int i);
      case (pat)
         0:       return (i % 2 != 0) ? 8'd200 : 8'd50;
         1:       return (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : (i == 2) ? 8'd255 : 8'd0;
         2:       return 8'd255;
         4:       return (i == 0 || i == PIXELS - 1) ? 8'd255 : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   task automatic stream(input int pat, input int n);
      for (int i = 0; i < n; i++) begin
         bus.pix_valid_i = 1'b1;
         bus.pix_data_i  = pix_val(pat, i);
         if (i == PIXELS - 1) chk("valid_before_last_beat", bus.model_valid_o, 0);
         tick();
      end
      bus.pix_valid_i = 1'b0;
      bus.pix_data_i  = 8'd0;
      if (n == PIXELS) begin
         chk("valid_after_last_beat", bus.model_valid_o, 1);
         chk("pix_ready_after_frame", bus.pix_ready_o, 0);
      end
   endtask

   task automatic send(input int hold, input logic [PIXELS-1:0] exp);
      for (int k = 0; k < hold; k++) begin
         chk("model_valid_held", bus.model_valid_o, 1);
         chk("model_data_held", bus.model_data_o, exp);
         chk("pix_ready_in_send", bus.pix_ready_o, 0);
         chk("model_ready_o_in_send", bus.model_ready_o, 0);
         if (k == 5) begin
            bus.model_valid_i = 1'b1;   // stray label, must be ignored
            bus.model_data_i  = 4'd3;
         end
         tick();
         bus.model_valid_i = 1'b0;
         bus.model_data_i  = '0;
      end
      bus.model_ready_i = 1'b1;
      tick();
      bus.model_ready_i = 1'b0;
      chk("model_valid_drop", bus.model_valid_o, 0);
      chk("model_ready_o_in_wait", bus.model_ready_o, 1);
   endtask

   task automatic respond(input logic [LABEL_W-1:0] lbl);
      bus.model_valid_i = 1'b1;
      bus.model_data_i  = lbl;
      tick();
      bus.model_valid_i = 1'b0;
      bus.model_data_i  = '0;
      chk("label_valid_after_pulse", bus.label_valid_o, 1);
   endtask

   task automatic collect(input int hold, input logic [LABEL_W:0] exp);
      for (int k = 0; k < hold; k++) begin
         chk("label_valid_held", bus.label_valid_o, 1);
         chk("label_held", {bus.label_err_o, bus.label_data_o}, exp);
         chk("pix_ready_in_out", bus.pix_ready_o, 0);
         tick();
      end
      bus.label_ready_i = 1'b1;
      tick();
      bus.label_ready_i = 1'b0;
      chk("label_valid_drop", bus.label_valid_o, 0);
      chk("back_to_load", bus.pix_ready_o, 1);
      chk("busy_idle", bus.busy_o, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pix_ready"},   bus.pix_ready_o,   1);
      chk({tag, "_model_valid"}, bus.model_valid_o, 0);
      chk({tag, "_model_data"},  bus.model_data_o,  0);
      chk({tag, "_model_ready"}, bus.model_ready_o, 0);
      chk({tag, "_label_valid"}, bus.label_valid_o, 0);
      chk({tag, "_label"},       {bus.label_err_o, bus.label_data_o}, 0);
      chk({tag, "_busy"},        bus.busy_o,        0);
   endtask

   // ---------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------
   initial begin
      logic [LABEL_W:0] range_exp;
      int n;
      bus.pix_valid_i   = 1'b0;
      bus.pix_data_i    = 8'd0;
      bus.model_ready_i = 1'b0;
      bus.model_valid_i = 1'b0;
      bus.model_data_i  = '0;
      bus.label_ready_i = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      reset_ni = 1'b1;
      tick();

      // basic frame, label 8 one cycle after acceptance
      frame_q.push_back(FRAME_ALT);
      stream(0, PIXELS);
      send(0, FRAME_ALT);
      label_q.push_back({1'b0, 4'd8});
      respond(4'd8);
      collect(0, {1'b0, 4'd8});
      chk("frame_retained", bus.model_data_o, FRAME_ALT);

      // threshold edge 127/128/255/0
      frame_q.push_back(FRAME_EDGE);
      stream(1, PIXELS);
      send(0, FRAME_EDGE);
      label_q.push_back({1'b0, 4'd2});
      respond(4'd2);
      collect(0, {1'b0, 4'd2});

      // backpressure on both ports, stray label in S_SEND
      frame_q.push_back(FRAME_ONES);
      stream(2, PIXELS);
      send(20, FRAME_ONES);
      label_q.push_back({1'b0, 4'd5});
      respond(4'd5);
      collect(10, {1'b0, 4'd5});

      // timeout: core never answers
      frame_q.push_back(FRAME_ZERO);
      stream(3, PIXELS);
      send(0, FRAME_ZERO);
      label_q.push_back({1'b1, 4'hF});
      n = 0;
      while (!bus.label_valid_o && n < 100) begin
         tick();
         n++;
      end
      chk("timeout_latency", n, TIMEOUT);
      collect(0, {1'b1, 4'hF});

      // label arriving on the timeout cycle wins
      frame_q.push_back(FRAME_ZERO);
      stream(3, PIXELS);
      send(0, FRAME_ZERO);
      repeat (TIMEOUT - 1) tick();
      chk("no_label_before_last_cycle", bus.label_valid_o, 0);
      label_q.push_back({1'b0, 4'd6});
      respond(4'd6);
      collect(0, {1'b0, 4'd6});

      // reset in the middle of a frame
      stream(2, 300);
      chk("busy_mid_frame", bus.busy_o, 1);
      reset_ni = 1'b0;
      #2;
      chk_reset_outputs("midreset");
      tick();
      reset_ni = 1'b1;
      tick();
      frame_q.push_back(FRAME_ENDS);
      stream(4, PIXELS);
      send(0, FRAME_ENDS);
      label_q.push_back({1'b0, 4'd7});
      respond(4'd7);
      collect(0, {1'b0, 4'd7});

      // out-of-range label 12
`ifdef LABEL_CHECK_EN
      range_exp = {1'b1, 4'hE};
`else
      range_exp = {1'b0, 4'hC};
`endif
      frame_q.push_back(FRAME_ALT);
      stream(0, PIXELS);
      send(0, FRAME_ALT);
      label_q.push_back(range_exp);
      respond(4'd12);
      collect(0, range_exp);

      repeat (3) tick();
      chk("model_handshakes", model_hs, 7);
      chk("label_handshakes", label_hs, 7);
      chk("frame_queue_empty", frame_q.size(), 0);
      chk("label_queue_empty", label_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no end of test, required finish within 1 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
